// File: rtl/rca_test_ctrl_pkg.sv
// Shared definitions for the ripple-carry-adder self-test controller.
//   state_t    : controller states (IDLE, INIT, APPLY, EVAL, DONE)
//   NUM_SLICES : number of 1-bit adder slices covered by the comparators
//   VEC_W      : width of the test vector index {cin, b[3:0], a[3:0]}
//   HOLD_W     : width of the per-vector hold counter (SETTLE <= 15)
package rca_test_ctrl_pkg;

    localparam int NUM_SLICES = 4;
    localparam int VEC_W      = 9;
    localparam int HOLD_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_APPLY = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rca_test_ctrl_tpg.sv
// Test pattern generator for the adder self-test.
// Holds the vector index and the per-vector hold counter, and drives the
// test operands. Operands read as zero whenever the sweep is not running.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : zero the index and hold counter
//   run          : sweep active (index/hold counter advance, operands valid)
//   vec_a, vec_b : operand nibbles, vec_cin : carry-in
//   last_sample  : final hold cycle of the current vector (sample comp now)
//   last_vec     : index has reached VEC_LAST
module rca_tpg
    import rca_test_ctrl_pkg::*;
#(
    parameter int VEC_LAST = 511,
    parameter int SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       run,
    output logic [3:0] vec_a,
    output logic [3:0] vec_b,
    output logic       vec_cin,
    output logic       last_sample,
    output logic       last_vec
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0]  IDX_MAX  = VEC_W'(VEC_LAST);

    logic [VEC_W-1:0]  index_reg, index_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;

    always_comb begin
        index_next = index_reg;
        hold_next  = hold_reg;
        if (clear) begin
            index_next = '0;
            hold_next  = '0;
        end else if (run) begin
            if (hold_reg == HOLD_MAX) begin
                hold_next = '0;
                // Saturate on the last vector: the controller leaves APPLY
                // on this same edge, so the index never wraps within a run.
                if (index_reg != IDX_MAX) begin
                    index_next = index_reg + VEC_W'(1);
                end
            end else begin
                hold_next = hold_reg + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_reg <= '0;
            hold_reg  <= '0;
        end else begin
            index_reg <= index_next;
            hold_reg  <= hold_next;
        end
    end

    assign last_sample = run && (hold_reg == HOLD_MAX);
    assign last_vec    = (index_reg == IDX_MAX);
    assign {vec_cin, vec_b, vec_a} = run ? index_reg : '0;

endmodule

// File: rtl/rca_test_ctrl.sv
// Built-in self-test controller for a 4-slice ripple-carry adder with
// duplicated slices. Sweeps every {cin, b, a} vector, holds each for SETTLE
// cycles, accumulates per-slice miscompares and reports a fault map.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a self-test (accepted only in IDLE)
//   comp[7:0]    : comparator mismatch flags, bits i and i+4 belong to slice i
//   init         : clear pulse for the select generator's fault register
//   test         : test mode for the select generator and mux network
//   vec_a/b/cin  : test operands (zero outside the sweep)
//   busy         : controller not idle
//   done         : one-cycle pulse, results valid
//   fault_map    : slices that miscompared on any sampled vector
//   multi_fault  : more than one faulty slice (not repairable with one spare)
module rca_test_ctrl
    import rca_test_ctrl_pkg::*;
#(
    parameter int VEC_LAST = 511,
    parameter int SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] comp,
    output logic       init,
    output logic       test,
    output logic [3:0] vec_a,
    output logic [3:0] vec_b,
    output logic       vec_cin,
    output logic       busy,
    output logic       done,
    output logic [3:0] fault_map,
    output logic       multi_fault
);

    localparam int CNT_W = $clog2(NUM_SLICES + 1);

    state_t                state_reg, state_next;
    logic [NUM_SLICES-1:0] slice_err;
    logic [NUM_SLICES-1:0] acc_reg, acc_next;
    logic [NUM_SLICES-1:0] fault_map_reg;
    logic                  multi_fault_reg;
    logic [CNT_W-1:0]      acc_ones;
    logic                  tpg_clear, tpg_run;
    logic                  last_sample, last_vec;

    // Each slice has two comparator taps; either one flags the slice.
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_fold
        assign slice_err[gi] = comp[gi] | comp[gi + NUM_SLICES];
    end

    rca_tpg #(
        .VEC_LAST (VEC_LAST),
        .SETTLE   (SETTLE)
    ) u_tpg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tpg_clear),
        .run         (tpg_run),
        .vec_a       (vec_a),
        .vec_b       (vec_b),
        .vec_cin     (vec_cin),
        .last_sample (last_sample),
        .last_vec    (last_vec)
    );

    // Next state and decoded outputs.
    always_comb begin
        state_next = state_reg;
        init       = 1'b0;
        test       = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        tpg_clear  = 1'b0;
        tpg_run    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                init       = 1'b1;
                tpg_clear  = 1'b1;
                state_next = ST_APPLY;
            end
            ST_APPLY: begin
                test    = 1'b1;
                tpg_run = 1'b1;
                if (last_sample && last_vec) begin
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                // start is deliberately not looked at here.
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Number of faulty slices in the accumulator.
    always_comb begin
        acc_ones = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            acc_ones = acc_ones + CNT_W'(acc_reg[i]);
        end
    end

    always_comb begin
        acc_next = acc_reg;
        if (state_reg == ST_INIT) begin
            acc_next = '0;
        end else if (last_sample) begin
            acc_next = acc_reg | slice_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            acc_reg         <= '0;
            fault_map_reg   <= '0;
            multi_fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            // Results persist across INIT; only EVAL (or reset) replaces them.
            if (state_reg == ST_EVAL) begin
                fault_map_reg   <= acc_reg;
                multi_fault_reg <= (acc_ones >= CNT_W'(2));
            end
        end
    end

    assign fault_map   = fault_map_reg;
    assign multi_fault = multi_fault_reg;

endmodule

// File: tb/tb_rca_test_ctrl.sv
// Self-checking bench for rca_test_ctrl: a run-offset model predicts every
// output each cycle; directed scenarios pin the model with literal results.
module tb_rca_test_ctrl;

    localparam int VEC_LAST = 511;
    localparam int SETTLE   = 2;
    localparam int NAPPLY   = (VEC_LAST + 1) * SETTLE;
    localparam int LAT      = 1 + NAPPLY + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] comp = 8'h00;
    logic       init, test, vec_cin, busy, done, multi_fault;
    logic [3:0] vec_a, vec_b, fault_map;

    rca_test_ctrl #(.VEC_LAST(VEC_LAST), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .comp        (comp),
        .init        (init),
        .test        (test),
        .vec_a       (vec_a),
        .vec_b       (vec_b),
        .vec_cin     (vec_cin),
        .busy        (busy),
        .done        (done),
        .fault_map   (fault_map),
        .multi_fault (multi_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a run is a sequence of offsets k after the accepting edge:
    // k=0 INIT, k=1..NAPPLY APPLY (vector (k-1)/SETTLE), NAPPLY+1 EVAL, NAPPLY+2 DONE.
    bit         m_active = 0;
    int         m_k = 0;
    logic [3:0] m_acc = 0, m_fault = 0;
    bit         m_multi = 0;
    int         m_start_cyc = 0;

    // Observation counters.
    int done_cnt = 0, test_cnt = 0, last_lat = 0, last_init_cyc = 0, last_done_cyc = 0;

    // Fault injection table and random noise rate (per mille).
    int inj_idx[$], inj_bit[$], inj_ph[$];
    int noise_pm = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_k = 0; m_acc = 0; m_fault = 0; m_multi = 0;
        end else begin
            cyc++;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_k = 0; m_acc = 0; m_start_cyc = cyc;
                end
            end else begin
                if (m_k >= 1 && m_k <= NAPPLY && ((m_k - 1) % SETTLE) == SETTLE - 1)
                    m_acc = m_acc | comp[3:0] | comp[7:4];
                if (m_k == NAPPLY + 1) begin
                    m_fault = m_acc;
                    m_multi = ($countones(m_acc) >= 2);
                end
                if (m_k == NAPPLY + 2) m_active = 0;
                else m_k++;
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        logic e_init, e_test, e_done;
        logic [8:0] e_vec;
        logic [17:0] e_all, a_all;
        @(negedge clk);
        e_init = m_active && m_k == 0;
        e_test = m_active && m_k >= 1 && m_k <= NAPPLY;
        e_done = m_active && m_k == NAPPLY + 2;
        e_vec  = e_test ? 9'((m_k - 1) / SETTLE) : 9'd0;
        e_all  = {e_init, e_test, e_vec, m_active, e_done, m_fault, m_multi};
        a_all  = {init, test, vec_cin, vec_b, vec_a, busy, done, fault_map, multi_fault};
        check("cycle_outputs", 32'(a_all), 32'(e_all));
        if (test) test_cnt++;
        if (init) last_init_cyc = cyc;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_lat = cyc - m_start_cyc + 1;
        end
    end

    // Comparator stimulus, driven 1 time unit after each rising edge.
    initial forever begin
        logic [7:0] c;
        int idx, ph;
        @(posedge clk);
        #1;
        c = 8'h00;
        if (m_active && m_k >= 1 && m_k <= NAPPLY) begin
            idx = (m_k - 1) / SETTLE;
            ph  = (m_k - 1) % SETTLE;
            foreach (inj_idx[i])
                if (inj_idx[i] == idx && (inj_ph[i] < 0 || inj_ph[i] == ph))
                    c[inj_bit[i]] = 1'b1;
        end
        if (noise_pm != 0 && $urandom_range(0, 999) < noise_pm)
            c = c | 8'(1 << $urandom_range(0, 7));
        comp = c;
    end

    task automatic wait_done(string name);
        int base = done_cnt;
        bit ok = 0;
        for (int i = 0; i < LAT + 50; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic add_inj(int idx, int b, int ph);
        inj_idx.push_back(idx); inj_bit.push_back(b); inj_ph.push_back(ph);
    endtask

    task automatic clear_inj();
        inj_idx.delete(); inj_bit.delete(); inj_ph.delete();
    endtask

    // One full sweep with literal expectations (exp_fm < 0: use model only).
    task automatic run_sweep(string name, int exp_fm, int exp_mf);
        test_cnt = 0;
        pulse_start();
        wait_done(name);
        if (exp_fm >= 0) begin
            check({name, "_fault_map"}, 32'(fault_map), 32'(exp_fm));
            check({name, "_multi_fault"}, 32'(multi_fault), 32'(exp_mf));
        end else begin
            check({name, "_fault_map"}, 32'(fault_map), 32'(m_fault));
            check({name, "_multi_fault"}, 32'(multi_fault), 32'(m_multi));
        end
        check({name, "_latency"}, 32'(last_lat), 32'(LAT));
        check({name, "_test_cycles"}, 32'(test_cnt), 32'(NAPPLY));
        $display("run %s: fault_map=%b multi_fault=%b latency=%0d test_cycles=%0d",
                 name, fault_map, multi_fault, last_lat, test_cnt);
    endtask

    initial begin
        int base, first_done;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({init, test, vec_cin, vec_b, vec_a, busy, done, fault_map, multi_fault}), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(busy), 0);

        run_sweep("fault_free", 4'b0000, 0);

        clear_inj(); add_inj(37, 6, -1);
        run_sweep("comp6_idx37", 4'b0100, 0);

        clear_inj(); add_inj(5, 1, -1); add_inj(300, 4, -1);
        run_sweep("two_slices", 4'b0011, 1);

        clear_inj(); add_inj(10, 0, 0);
        run_sweep("non_sample_cycle", 4'b0000, 0);

        // Reset abort after a run that left fault_map = 1000.
        clear_inj(); add_inj(200, 3, -1);
        run_sweep("prior_1000", 4'b1000, 0);
        clear_inj();
        base = done_cnt;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            if (m_active && m_k == 100) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              32'({init, test, vec_cin, vec_b, vec_a, busy, done, fault_map, multi_fault}), 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - base), 0);
        rst_n = 1'b1;
        $display("run abort: reset applied mid-sweep, fault_map=%b", fault_map);
        run_sweep("restart_after_abort", 4'b0000, 0);

        // start pulsed in INIT, mid-APPLY and in DONE.
        base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;          // INIT cycle, start still high
        @(posedge clk); #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored_starts");
        start = 1'b1;                // high during the DONE cycle only
        @(posedge clk); #1;
        start = 1'b0;
        repeat (LAT + 20) @(negedge clk);
        #1;
        check("one_done_per_start", 32'(done_cnt - base), 1);
        check("idle_after_ignored", 32'(busy), 0);
        $display("run ignored_starts: done pulses=%0d", done_cnt - base);

        // start held high: back-to-back runs.
        base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        wait_done("held_start_1");
        first_done = last_done_cyc;
        wait_done("held_start_2");
        start = 1'b0;
        check("held_start_gap", 32'(last_init_cyc - first_done), 2);
        repeat (4) @(posedge clk);
        #1;
        check("held_start_dones", 32'(done_cnt - base), 2);
        check("held_start_idle", 32'(busy), 0);
        $display("run held_start: done pulses=%0d init-after-done gap=%0d",
                 done_cnt - base, last_init_cyc - first_done);

        // Randomised runs: noise on every cycle plus random injected faults.
        for (int r = 0; r < 3; r++) begin
            clear_inj();
            noise_pm = 3;
            for (int j = 0; j < 2; j++)
                add_inj($urandom_range(0, VEC_LAST), $urandom_range(0, 7), SETTLE - 1);
            run_sweep($sformatf("random_%0d", r), -1, 0);
        end
        noise_pm = 0;
        clear_inj();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
